// File: rtl/ucsbece154b_branch_predictor_pkg.sv
// Shared encodings for the branch predictor: 2-bit direction counter states
// and the counter value loaded on reset.
package ucsbece154b_branch_predictor_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,  // strongly not taken
    CTR_WNT = 2'b01,  // weakly not taken
    CTR_WT  = 2'b10,  // weakly taken
    CTR_ST  = 2'b11   // strongly taken
  } ctr_e;

  localparam logic [1:0] CTR_RESET = CTR_WNT;

  // The counter's upper bit is the predicted direction.
  function automatic logic ctr_predicts_taken(input logic [1:0] ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/ucsbece154b_sat_counter.sv
// 2-bit saturating counter next-state function. Purely combinational; the
// predictor instances it once on the execute-side update path.
module ucsbece154b_sat_counter
  import ucsbece154b_branch_predictor_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  // Step towards the resolved direction, holding at either end.
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/ucsbece154b_branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus a table of 2-bit counters.
// Fetch side looks up combinationally on PCF_i; execute side updates on
// resolved branches/jumps. Configuration macro: GSHARE_EN (when defined the
// PHT is indexed by PC bits XOR global history, otherwise bimodal).
//
// Handshake note: there is no valid/ready protocol here. A lookup is implied
// every cycle on PCF_i; an update is implied on any rising edge where
// BranchE_i | JumpE_i is high, and reset on that same edge discards it.
module ucsbece154b_branch_predictor
  import ucsbece154b_branch_predictor_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             PCF_i,
  output logic                    PredTakenF_o,
  output logic [31:0]             BTBTargetF_o,
  output logic [NUM_GHR_BITS-1:0] PHTIndexF_o,
  input  logic [31:0]             PCE_i,
  input  logic                    BranchE_i,
  input  logic                    JumpE_i,
  input  logic                    TakenE_i,
  input  logic [31:0]             PCTargetE_i,
  input  logic                    PredTakenE_i,
  input  logic [31:0]             PredTargetE_i,
  input  logic [NUM_GHR_BITS-1:0] PHTIndexE_i,
  output logic                    MispredictE_o
);

  localparam int BTB_IDX = $clog2(NUM_BTB_ENTRIES);
  localparam int TAG_W   = 30 - BTB_IDX;
  localparam int PHT_N   = 1 << NUM_GHR_BITS;

  logic              btb_valid_q  [NUM_BTB_ENTRIES];
  logic              btb_valid_d  [NUM_BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag_q    [NUM_BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag_d    [NUM_BTB_ENTRIES];
  logic [31:0]       btb_target_q [NUM_BTB_ENTRIES];
  logic [31:0]       btb_target_d [NUM_BTB_ENTRIES];
  logic              btb_jump_q   [NUM_BTB_ENTRIES];
  logic              btb_jump_d   [NUM_BTB_ENTRIES];
  logic [1:0]        pht_q        [PHT_N];
  logic [1:0]        pht_d        [PHT_N];
  logic [NUM_GHR_BITS-1:0] ghr_q, ghr_d;

  logic [BTB_IDX-1:0] f_idx, e_idx;
  logic [TAG_W-1:0]   f_tag, e_tag;
  logic               f_hit;
  logic [1:0]         pht_upd_ctr;
  logic               is_branch_upd;
  logic [NUM_GHR_BITS:0] ghr_shift;

  // Word-offset bits of both PCs carry no information for the predictor.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{PCF_i[1:0], PCE_i[1:0]};

  assign f_idx = PCF_i[BTB_IDX+1:2];
  assign f_tag = PCF_i[31:BTB_IDX+2];
  assign e_idx = PCE_i[BTB_IDX+1:2];
  assign e_tag = PCE_i[31:BTB_IDX+2];

  // A jump in E suppresses any simultaneous (illegal) branch indication.
  assign is_branch_upd = BranchE_i && !JumpE_i;

  ucsbece154b_sat_counter u_sat_counter (
    .ctr_i   (pht_q[PHTIndexE_i]),
    .taken_i (TakenE_i),
    .ctr_o   (pht_upd_ctr)
  );

  // Fetch-side lookup from registered state only, so a same-cycle update is not visible.
  always_comb begin
`ifdef GSHARE_EN
    PHTIndexF_o = PCF_i[NUM_GHR_BITS+1:2] ^ ghr_q;
`else
    PHTIndexF_o = PCF_i[NUM_GHR_BITS+1:2];
`endif
    f_hit        = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
    PredTakenF_o = f_hit && (btb_jump_q[f_idx] || ctr_predicts_taken(pht_q[PHTIndexF_o]));
    BTBTargetF_o = f_hit ? btb_target_q[f_idx] : 32'd0;
  end

  // Execute-side redirect: wrong direction, or taken to a different target.
  always_comb begin
    MispredictE_o = (BranchE_i || JumpE_i) &&
                    ((PredTakenE_i != TakenE_i) ||
                     (TakenE_i && (PredTargetE_i != PCTargetE_i)));
  end

  // Next-state for BTB, PHT and history from the resolved E instruction.
  always_comb begin
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    btb_jump_d   = btb_jump_q;
    pht_d        = pht_q;
    ghr_d        = ghr_q;
    ghr_shift    = {ghr_q, TakenE_i};
    if ((BranchE_i || JumpE_i) && TakenE_i) begin
      btb_valid_d[e_idx]  = 1'b1;
      btb_tag_d[e_idx]    = e_tag;
      btb_target_d[e_idx] = PCTargetE_i;
      btb_jump_d[e_idx]   = JumpE_i;
    end
    if (is_branch_upd) begin
      pht_d[PHTIndexE_i] = pht_upd_ctr;
      ghr_d              = ghr_shift[NUM_GHR_BITS-1:0];
    end
  end

  // State registers; reset wins over any update on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
        btb_jump_q[i]   <= 1'b0;
      end
      for (int j = 0; j < PHT_N; j++) pht_q[j] <= CTR_RESET;
      ghr_q <= '0;
    end else begin
      btb_valid_q  <= btb_valid_d;
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
      btb_jump_q   <= btb_jump_d;
      pht_q        <= pht_d;
      ghr_q        <= ghr_d;
    end
  end

endmodule
